// File: rtl/eab_pipe.sv
// Effective-address pipe: base + scaled sign-extended offset, with optional one-level
// indirection through a memory read, and a valid/ready handshake on both ends.
module eab_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OFF_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      ir_slice,
    input  logic [WIDTH-1:0] base_r,
    input  logic [WIDTH-1:0] pc,
    input  logic             addr1_sel,
    input  logic [1:0]       addr2_sel,
    input  logic             indirect,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ea_out
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StIndReq = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] ea_q, ea_d;

    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] off_shl;
    logic [WIDTH-1:0] base_sel;
    logic [WIDTH-1:0] sum;

    always_comb begin
        off_ext = '0;
        unique case (addr2_sel)
            2'd0: off_ext = '0;
            2'd1: off_ext = {{(WIDTH-6){ir_slice[5]}}, ir_slice[5:0]};
            2'd2: off_ext = {{(WIDTH-9){ir_slice[8]}}, ir_slice[8:0]};
            2'd3: off_ext = {{(WIDTH-11){ir_slice[10]}}, ir_slice[10:0]};
            default: off_ext = '0;
        endcase
    end

    // Carry out of the add is intentionally dropped: addresses wrap.
    assign off_shl  = off_ext << OFF_SHIFT;
    assign base_sel = addr1_sel ? base_r : pc;
    assign sum      = base_sel + off_shl;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ea_d       = ea_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (indirect) begin
                        mem_addr_d = sum;
                        state_d    = StIndReq;
                    end else begin
                        ea_d    = sum;
                        state_d = StDone;
                    end
                end
            end
            StIndReq: begin
                if (mem_ack) begin
                    ea_d    = mem_rdata;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            ea_q       <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ea_q       <= ea_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign mem_req   = (state_q == StIndReq);
    assign out_valid = (state_q == StDone);
    assign mem_addr  = mem_addr_q;
    assign ea_out    = ea_q;

endmodule

// File: tb/tb_eab_pipe.sv
// Bench for eab_pipe (WIDTH=16, OFF_SHIFT=1): vector table applied in a loop, expected
// results queued at issue and popped at the output handshake, plus hand-written corner cases.
module tb_eab_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] ir_slice;
    logic [15:0] base_r;
    logic [15:0] pc;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic        indirect;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ea_out;

    eab_pipe #(
        .WIDTH     (16),
        .OFF_SHIFT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir_slice  (ir_slice),
        .base_r    (base_r),
        .pc        (pc),
        .addr1_sel (addr1_sel),
        .addr2_sel (addr2_sel),
        .indirect  (indirect),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ea_out    (ea_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base_r;
        logic [15:0] pc;
        logic        a1;
        logic [1:0]  a2;
        logic [10:0] ir;
        logic        ind;
        logic [15:0] rdata;
        int          wait_n;
        int          hold_n;
        logic [15:0] exp_ea;
        logic [15:0] exp_maddr;
    } vec_t;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] sb_q[$];
    logic [15:0] last_ea;
    vec_t        tbl[$];

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent integer model of the address arithmetic.
    function automatic logic [15:0] ref_ea(input logic [15:0] b, input logic [15:0] p,
                                           input logic a1, input logic [1:0] a2,
                                           input logic [10:0] ir);
        int          off;
        int          base;
        logic [31:0] s;
        case (a2)
            2'd0:    off = 0;
            2'd1:    off = int'(ir[5:0]) - (ir[5] ? 64 : 0);
            2'd2:    off = int'(ir[8:0]) - (ir[8] ? 512 : 0);
            default: off = int'(ir) - (ir[10] ? 2048 : 0);
        endcase
        base = a1 ? int'(b) : int'(p);
        s = 32'(base + off * 2);
        return s[15:0];
    endfunction

    function automatic vec_t mkvec(input logic [15:0] b, input logic [15:0] p, input logic a1,
                                   input logic [1:0] a2, input logic [10:0] ir, input logic ind,
                                   input logic [15:0] rd, input int w, input int h,
                                   input logic [15:0] ea, input logic [15:0] ma);
        vec_t v;
        v.base_r = b; v.pc = p; v.a1 = a1; v.a2 = a2; v.ir = ir; v.ind = ind;
        v.rdata = rd; v.wait_n = w; v.hold_n = h; v.exp_ea = ea; v.exp_maddr = ma;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        in_valid  = 1'b1;
        base_r    = v.base_r;
        pc        = v.pc;
        addr1_sel = v.a1;
        addr2_sel = v.a2;
        ir_slice  = v.ir;
        indirect  = v.ind;
    endtask

    task automatic scramble_inputs();
        in_valid  = 1'b0;
        base_r    = 16'($urandom);
        pc        = 16'($urandom);
        addr1_sel = 1'($urandom);
        addr2_sel = 2'($urandom);
        ir_slice  = 11'($urandom);
        indirect  = 1'($urandom);
    endtask

    // Entered and left at a negedge drive point with the DUT idle.
    task automatic run_vec(input vec_t v);
        logic [15:0] exp;
        chk_b("idle_in_ready", in_ready, 1'b1);
        drive_req(v);
        sb_q.push_back(v.exp_ea);
        @(negedge clk);
        scramble_inputs();
        if (v.ind) begin
            for (int k = 0; k <= v.wait_n; k++) begin
                chk_b("ind_mem_req", mem_req, 1'b1);
                chk_b("ind_out_valid", out_valid, 1'b0);
                chk_b("ind_in_ready", in_ready, 1'b0);
                chk_w("ind_mem_addr", mem_addr, v.exp_maddr);
                mem_ack   = (k == v.wait_n);
                mem_rdata = (k == v.wait_n) ? v.rdata : 16'($urandom);
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        exp = sb_q[0];
        for (int h = 0; h <= v.hold_n; h++) begin
            chk_b("done_out_valid", out_valid, 1'b1);
            chk_b("done_mem_req", mem_req, 1'b0);
            chk_b("done_in_ready", in_ready, 1'b0);
            chk_w("done_ea_out", ea_out, exp);
            out_ready = (h == v.hold_n);
            @(negedge clk);
        end
        void'(sb_q.pop_front());
        out_ready = 1'b0;
        chk_b("post_out_valid", out_valid, 1'b0);
        chk_b("post_in_ready", in_ready, 1'b1);
        chk_w("post_ea_hold", ea_out, exp);
        last_ea = exp;
    endtask

    initial begin
        vec_t va, vb, vr;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
        base_r = 16'h0; pc = 16'h0; addr1_sel = 1'b0; addr2_sel = 2'd0;
        ir_slice = 11'h0; indirect = 1'b0;

        tbl.push_back(mkvec(16'h1111, 16'h3000, 1'b0, 2'd2, 11'h5FF, 1'b0, 16'h0, 0, 0,
                            16'h2FFE, 16'h0));
        tbl.push_back(mkvec(16'h4000, 16'h9999, 1'b1, 2'd1, 11'h7DF, 1'b0, 16'h0, 0, 3,
                            16'h403E, 16'h0));
        tbl.push_back(mkvec(16'hFFFF, 16'h0000, 1'b1, 2'd3, 11'h001, 1'b0, 16'h0, 0, 0,
                            16'h0001, 16'h0));
        tbl.push_back(mkvec(16'h7777, 16'h3000, 1'b0, 2'd0, 11'h7FF, 1'b1, 16'h5555, 2, 0,
                            16'h5555, 16'h3000));
        tbl.push_back(mkvec(16'h7777, 16'h3000, 1'b0, 2'd0, 11'h7FF, 1'b1, 16'hA5A5, 0, 0,
                            16'hA5A5, 16'h3000));
        tbl.push_back(mkvec(16'h1234, 16'h0000, 1'b1, 2'd1, 11'h020, 1'b0, 16'h0, 0, 1,
                            16'h11F4, 16'h0));
        tbl.push_back(mkvec(16'h0000, 16'h0010, 1'b0, 2'd3, 11'h400, 1'b0, 16'h0, 0, 0,
                            16'hF810, 16'h0));
        tbl.push_back(mkvec(16'h2000, 16'h0000, 1'b1, 2'd2, 11'h0FF, 1'b1, 16'hBEEF, 1, 1,
                            16'hBEEF, 16'h21FE));
        for (int i = 0; i < 6; i++) begin
            vr.base_r = 16'($urandom); vr.pc = 16'($urandom); vr.a1 = 1'($urandom);
            vr.a2 = 2'($urandom); vr.ir = 11'($urandom); vr.ind = 1'($urandom);
            vr.rdata = 16'($urandom); vr.wait_n = int'($urandom_range(0, 2));
            vr.hold_n = int'($urandom_range(0, 1));
            vr.exp_maddr = ref_ea(vr.base_r, vr.pc, vr.a1, vr.a2, vr.ir);
            vr.exp_ea = vr.ind ? vr.rdata : vr.exp_maddr;
            tbl.push_back(vr);
        end

        // Reset values, asserted before any clock edge.
        #1;
        chk_b("rst_in_ready", in_ready, 1'b1);
        chk_b("rst_mem_req", mem_req, 1'b0);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_w("rst_mem_addr", mem_addr, 16'h0);
        chk_w("rst_ea_out", ea_out, 16'h0);
        #1 rst_n = 1'b1;

        // First vector is accepted on the first rising edge after reset release.
        foreach (tbl[i]) run_vec(tbl[i]);

        // Stray ack in IDLE must do nothing.
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        chk_b("stray_ack_in_ready", in_ready, 1'b1);
        chk_b("stray_ack_mem_req", mem_req, 1'b0);
        chk_b("stray_ack_out_valid", out_valid, 1'b0);
        chk_w("stray_ack_ea_out", ea_out, last_ea);

        // Request B held pending while A sits in DONE; B accepted on the first IDLE cycle.
        va = mkvec(16'h0100, 16'h0, 1'b1, 2'd1, 11'h001, 1'b0, 16'h0, 0, 0, 16'h0102, 16'h0);
        vb = mkvec(16'h0, 16'h0200, 1'b0, 2'd2, 11'h003, 1'b0, 16'h0, 0, 0, 16'h0206, 16'h0);
        drive_req(va);
        sb_q.push_back(va.exp_ea);
        @(negedge clk);
        drive_req(vb);
        sb_q.push_back(vb.exp_ea);
        chk_b("pend_out_valid0", out_valid, 1'b1);
        chk_w("pend_ea0", ea_out, sb_q[0]);
        @(negedge clk);
        chk_b("pend_in_ready1", in_ready, 1'b0);
        chk_w("pend_ea1", ea_out, sb_q[0]);
        out_ready = 1'b1;
        @(negedge clk);
        void'(sb_q.pop_front());
        out_ready = 1'b0;
        chk_b("pend_idle_in_ready", in_ready, 1'b1);
        chk_b("pend_idle_out_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk_b("pend_b_out_valid", out_valid, 1'b1);
        chk_w("pend_b_ea", ea_out, sb_q[0]);
        out_ready = 1'b1;
        @(negedge clk);
        void'(sb_q.pop_front());
        out_ready = 1'b0;
        chk_b("pend_b_done", in_ready, 1'b1);

        // Asynchronous reset in the middle of an indirect wait; late ack is ignored.
        vr = mkvec(16'h0, 16'h3000, 1'b0, 2'd0, 11'h0, 1'b1, 16'h1234, 0, 0, 16'h1234, 16'h3000);
        drive_req(vr);
        @(negedge clk);
        scramble_inputs();
        chk_b("rstmid_mem_req_pre", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_b("rstmid_mem_req", mem_req, 1'b0);
        chk_b("rstmid_in_ready", in_ready, 1'b1);
        chk_b("rstmid_out_valid", out_valid, 1'b0);
        chk_w("rstmid_mem_addr", mem_addr, 16'h0);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk_b("late_ack_out_valid", out_valid, 1'b0);
        chk_b("late_ack_mem_req", mem_req, 1'b0);
        chk_b("late_ack_in_ready", in_ready, 1'b1);
        chk_w("late_ack_ea_out", ea_out, 16'h0);

        // Normal operation resumes after reset.
        run_vec(tbl[3]);
        run_vec(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
